// File: rtl/axi_lite_data_mem_slave.sv
// AXI4-Lite responder for the processor data memory.
// Handles byte-strobed writes and registered single-beat reads, and returns SLVERR for word indices outside DEPTH.
module axi_lite_data_mem_slave #(
   parameter int unsigned DEPTH     = 128,
   parameter logic [31:0] RESET_VAL = 32'h0000_0005
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready
);
   localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_W     = 30'(DEPTH);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic        aw_held_q, aw_held_d;
   logic        w_held_q, w_held_d;
   logic [29:0] aw_word_q, aw_word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;

   logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic             commit, wr_in_range, rd_in_range;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      mem_rd [DEPTH];
   logic             unused_addr_lsbs;

   assign s_awready = !aw_held_q && !bvalid_q;
   assign s_wready  = !w_held_q && !bvalid_q;
   assign s_arready = !rvalid_q;
   assign s_bvalid  = bvalid_q;
   assign s_bresp   = bresp_q;
   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

   assign aw_hs  = s_awvalid && s_awready;
   assign w_hs   = s_wvalid && s_wready;
   assign ar_hs  = s_arvalid && s_arready;
   assign b_hs   = bvalid_q && s_bready;
   assign r_hs   = rvalid_q && s_rready;
   assign commit = aw_held_q && w_held_q && !bvalid_q;

   assign wr_in_range      = aw_word_q < DEPTH_W;
   assign rd_in_range      = s_araddr[31:2] < DEPTH_W;
   assign rd_idx           = s_araddr[IDX_W+1:2];
   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

   always_comb begin
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      aw_word_d = aw_word_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_word_d = s_awaddr[31:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_wdata;
         wstrb_d  = s_wstrb;
      end
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
         bvalid_d = 1'b0;
      end

      // The array is read before this edge's commit lands, so a colliding read sees the old word.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_in_range ? mem_rd[rd_idx] : 32'h0;
         rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_word_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         aw_word_q <= aw_word_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Every word must reload RESET_VAL on reset, so each word is its own resettable register.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [31:0] word_q;
         logic        word_we;

         assign word_we = commit && (aw_word_q == 30'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_q <= RESET_VAL;
            end else if (word_we) begin
               for (int b = 0; b < 4; b++) begin
                  if (wstrb_q[b]) word_q[8*b +: 8] <= wdata_q[8*b +: 8];
               end
            end
         end

         assign mem_rd[gi] = word_q;
      end
   endgenerate
endmodule

// File: tb/tb_axi_lite_data_mem_slave.sv
// Directed bench for axi_lite_data_mem_slave.
// Uses a vector table for single transactions plus hand sequences for ordering, stall, collision and reset corners.
module tb_axi_lite_data_mem_slave;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vec [15];

   axi_lite_data_mem_slave dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Entry and exit at posedge+1; AW and W presented together, bready high.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      check("awready_idle", s_awready, 1);
      check("wready_idle", s_wready, 1);
      s_awaddr = a; s_awvalid = 1'b1;
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
      s_bready = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check("bvalid_not_early", s_bvalid, 0);
      tick();
      check("bvalid_latency", s_bvalid, 1);
      resp = s_bresp;
      tick();
      check("bvalid_clear", s_bvalid, 0);
      s_bready = 1'b0;
      $display("txn write addr=%h data=%h strb=%b bresp=%b", a, d, s, resp);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      check("arready_idle", s_arready, 1);
      s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check("rvalid_latency", s_rvalid, 1);
      d = s_rdata;
      resp = s_rresp;
      tick();
      check("rvalid_clear", s_rvalid, 0);
      s_rready = 1'b0;
      $display("txn read  addr=%h rdata=%h rresp=%b", a, d, resp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rsp;

      vec[0]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'b00, 32'h0000_0005};
      vec[1]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
      vec[2]  = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
      vec[3]  = '{1'b0, 32'h0000_000B, 32'h0, 4'h0, 2'b00, 32'hDEAD_BEEF};
      vec[4]  = '{1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
      vec[5]  = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 2'b10, 32'h0000_0000};
      vec[6]  = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 2'b00, 32'h0000_0005};
      vec[7]  = '{1'b0, 32'h0000_01FC, 32'h0, 4'h0, 2'b00, 32'h0000_0005};
      vec[8]  = '{1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 4'b1100, 2'b00, 32'h0};
      vec[9]  = '{1'b0, 32'h0000_01FC, 32'h0, 4'h0, 2'b00, 32'hCAFE_0005};
      vec[10] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h0};
      vec[11] = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 2'b00, 32'h0000_0005};
      vec[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_BAD0, 4'hF, 2'b10, 32'h0};
      vec[13] = '{1'b0, 32'h0000_01FC, 32'h0, 4'h0, 2'b00, 32'hCAFE_0005};
      vec[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 2'b10, 32'h0000_0000};

      // Reset state
      tick(); tick();
      check("rst_rvalid", s_rvalid, 0);
      check("rst_bvalid", s_bvalid, 0);
      check("rst_rdata", s_rdata, 32'h0);
      check("rst_bresp", s_bresp, 0);
      check("rst_rresp", s_rresp, 0);
      rst_n = 1'b1;
      tick();
      check("rst_awready", s_awready, 1);
      check("rst_wready", s_wready, 1);
      check("rst_arready", s_arready, 1);

      for (int i = 0; i < 15; i++) begin
         if (vec[i].is_write) begin
            do_write(vec[i].addr, vec[i].data, vec[i].strb, rsp);
            check($sformatf("vec%0d_bresp", i), rsp, vec[i].exp_resp);
         end else begin
            do_read(vec[i].addr, rd, rsp);
            check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_data);
            check($sformatf("vec%0d_rresp", i), rsp, vec[i].exp_resp);
         end
      end

      // W three cycles ahead of AW, partial strobe over the reset value
      s_wdata = 32'h1122_3344; s_wstrb = 4'b0101; s_wvalid = 1'b1; s_bready = 1'b1;
      tick();
      s_wvalid = 1'b0;
      check("wfirst_wready_held", s_wready, 0);
      check("wfirst_awready", s_awready, 1);
      repeat (2) begin
         tick();
         check("wfirst_no_bvalid", s_bvalid, 0);
      end
      s_awaddr = 32'h0000_000C; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
      check("wfirst_bvalid_early", s_bvalid, 0);
      tick();
      check("wfirst_bvalid", s_bvalid, 1);
      check("wfirst_bresp", s_bresp, 2'b00);
      tick();
      s_bready = 1'b0;
      $display("txn write addr=0000000c data=11223344 strb=0101 (W before AW)");
      do_read(32'h0000_000C, rd, rsp);
      check("wfirst_rdata", rd, 32'h0022_0044);

      // B channel stalled for 5 cycles with a new AW/W waiting
      s_awaddr = 32'h0000_0014; s_awvalid = 1'b1;
      s_wdata = 32'h0000_0077; s_wstrb = 4'hF; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      tick();
      check("stall_bvalid_up", s_bvalid, 1);
      s_awaddr = 32'h0000_0018; s_awvalid = 1'b1;
      s_wdata = 32'h0000_0099; s_wvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_bvalid", s_bvalid, 1);
         check("stall_bresp", s_bresp, 2'b00);
         check("stall_awready", s_awready, 0);
         check("stall_wready", s_wready, 0);
      end
      s_bready = 1'b1;
      tick();
      check("stall_b_done", s_bvalid, 0);
      check("stall_awready_back", s_awready, 1);
      check("stall_wready_back", s_wready, 1);
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check("stall_aw_taken", s_awready, 0);
      tick();
      check("stall_b2_valid", s_bvalid, 1);
      check("stall_b2_resp", s_bresp, 2'b00);
      tick();
      s_bready = 1'b0;
      $display("txn write addr=00000014 then 00000018 (bready stall)");
      do_read(32'h0000_0014, rd, rsp);
      check("stall_rd14", rd, 32'h0000_0077);
      do_read(32'h0000_0018, rd, rsp);
      check("stall_rd18", rd, 32'h0000_0099);

      // AR handshake on the same edge as the commit to the same word
      s_awaddr = 32'h0000_0004; s_awvalid = 1'b1;
      s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 32'h0000_0004; s_arvalid = 1'b1; s_rready = 1'b0;
      tick();
      s_arvalid = 1'b0;
      check("coll_bvalid", s_bvalid, 1);
      check("coll_rvalid", s_rvalid, 1);
      check("coll_rdata_old", s_rdata, 32'h0000_0005);
      check("coll_rresp", s_rresp, 2'b00);
      tick();
      check("coll_rvalid_hold", s_rvalid, 1);
      check("coll_rdata_hold", s_rdata, 32'h0000_0005);
      check("coll_arready_low", s_arready, 0);
      s_rready = 1'b1;
      tick();
      check("coll_rvalid_clear", s_rvalid, 0);
      s_rready = 1'b0; s_bready = 1'b0;
      $display("txn write+read addr=00000004 collision rdata=00000005");
      do_read(32'h0000_0004, rd, rsp);
      check("coll_rdata_new", rd, 32'hA5A5_A5A5);

      // Asynchronous reset while a read response is pending
      s_araddr = 32'h0000_0008; s_arvalid = 1'b1; s_rready = 1'b0;
      tick();
      s_arvalid = 1'b0;
      check("arst_rvalid_pre", s_rvalid, 1);
      check("arst_rdata_pre", s_rdata, 32'hDEAD_BEEF);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_rvalid_now", s_rvalid, 0);
      check("arst_rdata_now", s_rdata, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      $display("txn async reset during pending read");
      do_read(32'h0000_0008, rd, rsp);
      check("arst_rd08", rd, 32'h0000_0005);
      do_read(32'h0000_0004, rd, rsp);
      check("arst_rd04", rd, 32'h0000_0005);
      do_read(32'h0000_01FC, rd, rsp);
      check("arst_rd1fc", rd, 32'h0000_0005);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
